// File: rtl/traffic_req_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : traffic_req_conditioner
// Description : Input conditioning stage for the four-way intersection light
//               controller. Two-flop synchronises and debounces the raw road
//               sensors, emergency detectors and pedestrian buttons, arbitrates
//               emergency requests to a held one-hot grant, and latches
//               pedestrian presses until the controller reports service.
//
// Ports       : clk            - system clock, rising edge
//               reset          - asynchronous, active-low reset
//               raw_traffic    - [3:0] async vehicle-presence sensors
//               raw_emergency  - [3:0] async emergency-vehicle detectors
//               raw_ped        - [3:0] async pedestrian buttons
//               ped_served     - [3:0] crossing currently walking (clears latch)
//               traffic        - [3:0] debounced vehicle presence
//               emergency      - [3:0] one-hot (or zero) emergency grant
//               pedastrain_req - [3:0] latched pedestrian requests
//               emg_active     - high whenever emergency is non-zero
//
//               Bit order of all vectors: [3]=east [2]=west [1]=north [0]=south
//
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_req_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EMG_HOLD        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw_traffic,
  input  logic [3:0] raw_emergency,
  input  logic [3:0] raw_ped,
  input  logic [3:0] ped_served,
  output logic [3:0] traffic,
  output logic [3:0] emergency,
  output logic [3:0] pedastrain_req,
  output logic       emg_active
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_NBITS  = 12;
  localparam int c_CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_HOLD_W = $clog2(EMG_HOLD + 1);

  // A bit flips on the mismatch that arrives while the counter already holds
  // DEBOUNCE_CYCLES-1, i.e. on the DEBOUNCE_CYCLES-th consecutive mismatch.
  localparam logic [c_CNT_W-1:0]  c_DB_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(EMG_HOLD - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_GRANT = 2'd1;
  localparam logic [1:0] c_ST_HOLD  = 2'd2;

  // --------------------------------------------------------------------------
  // Synchronisers: all twelve raw bits share one two-flop chain.
  // Packing: [3:0] traffic, [7:4] emergency, [11:8] pedestrian.
  // --------------------------------------------------------------------------
  logic [c_NBITS-1:0] w_raw_all;
  logic [c_NBITS-1:0] r_sync1;
  logic [c_NBITS-1:0] r_sync2;

  assign w_raw_all = {raw_ped, raw_emergency, raw_traffic};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw_all;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: per bit, count consecutive cycles where the synchronised value
  // disagrees with the debounced value; any agreeing cycle restarts the count.
  // --------------------------------------------------------------------------
  logic [c_NBITS-1:0] w_db;

  generate
    for (genvar gi = 0; gi < c_NBITS; gi++) begin : g_db
      logic [c_CNT_W-1:0] r_cnt;
      logic               r_bit;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
          r_bit <= 1'b0;
        end else if (r_sync2[gi] == r_bit) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_bit <= r_sync2[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end

      assign w_db[gi] = r_bit;
    end
  endgenerate

  logic [3:0] w_db_traffic;
  logic [3:0] w_db_emg;
  logic [3:0] w_db_ped;

  assign w_db_traffic = w_db[3:0];
  assign w_db_emg     = w_db[7:4];
  assign w_db_ped     = w_db[11:8];

  assign traffic = w_db_traffic;

  // --------------------------------------------------------------------------
  // Emergency arbiter
  // --------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [3:0]          r_grant;
  logic [3:0]          w_grant_nxt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [c_HOLD_W-1:0] w_hold_cnt_nxt;
  logic [3:0]          w_pick;
  logic                w_granted_live;

  // Fixed priority east > west > north > south.
  always_comb begin
    w_pick = 4'b0000;
    if (w_db_emg[3])      w_pick = 4'b1000;
    else if (w_db_emg[2]) w_pick = 4'b0100;
    else if (w_db_emg[1]) w_pick = 4'b0010;
    else if (w_db_emg[0]) w_pick = 4'b0001;
  end

  // Only the currently granted direction matters once a grant is issued;
  // other requests wait until the arbiter returns to IDLE.
  assign w_granted_live = |(w_db_emg & r_grant);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_ST_IDLE;
      r_grant    <= 4'b0000;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (|w_db_emg) begin
          w_state_nxt = c_ST_GRANT;
          w_grant_nxt = w_pick;
        end
      end
      c_ST_GRANT: begin
        if (!w_granted_live) begin
          w_state_nxt    = c_ST_HOLD;
          w_hold_cnt_nxt = c_HOLD_LOAD;
        end
      end
      c_ST_HOLD: begin
        if (w_granted_live) begin
          w_state_nxt = c_ST_GRANT;
        end else if (r_hold_cnt == '0) begin
          // Clearing here and arbitrating only from IDLE guarantees at least
          // one all-zero cycle between consecutive grants.
          w_state_nxt = c_ST_IDLE;
          w_grant_nxt = 4'b0000;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - c_HOLD_ONE;
        end
      end
      default: begin
        w_state_nxt    = c_ST_IDLE;
        w_grant_nxt    = 4'b0000;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    emergency  = r_grant;
    emg_active = |r_grant;
  end

  // --------------------------------------------------------------------------
  // Pedestrian request latches
  // --------------------------------------------------------------------------
  logic [3:0] r_ped_prev;
  logic [3:0] r_ped_latch;
  logic [3:0] w_ped_rise;

  // Edge detection means a button held through service cannot re-request.
  assign w_ped_rise = w_db_ped & ~r_ped_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ped_prev  <= 4'b0000;
      r_ped_latch <= 4'b0000;
    end else begin
      r_ped_prev  <= w_db_ped;
      // A new press in the same cycle as service wins over the clear.
      r_ped_latch <= (r_ped_latch & ~ped_served) | w_ped_rise;
    end
  end

  // Requests are masked (not discarded) while an emergency grant is out.
  assign pedastrain_req = r_ped_latch & {4{~emg_active}};

endmodule
`default_nettype wire

// File: doc/traffic_req_conditioner.md
# traffic_req_conditioner

Upstream input stage for the four-way intersection light controller. Synchronises and debounces raw road sensors, emergency-vehicle detectors and pedestrian push-buttons, then presents clean `traffic`, `emergency` and `pedastrain_req` vectors to the controller. Emergency requests are arbitrated to one-hot with a minimum hold time. Pedestrian presses are latched until the controller signals service.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required before a debounced bit changes (≥1).
- `EMG_HOLD`, default 16: cycles an emergency grant is held after its request drops (≥1).
- Bit order for all 4-bit vectors: [3]=east, [2]=west, [1]=north, [0]=south.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `raw_traffic`  in  4  asynchronous vehicle-presence sensors.
- `raw_emergency`  in  4  asynchronous emergency-vehicle detectors.
- `raw_ped`  in  4  asynchronous pedestrian buttons.
- `ped_served`  in  4  from controller `{P_east,P_west,P_north,P_south}`; high means that crossing is currently walking.
- `traffic`  out  4  debounced vehicle presence (level).
- `emergency`  out  4  one-hot or zero emergency grant.
- `pedastrain_req`  out  4  latched pedestrian requests.
- `emg_active`  out  1  high whenever `emergency` is non-zero.

## Operation
- Synchronisation: two-flop synchroniser on each of the 12 raw bits.
- Debounce, per bit:
  - Counter counts consecutive cycles where the synchronised value ≠ the debounced value.
  - Any matching cycle clears the counter.
  - When DEBOUNCE_CYCLES mismatches accumulate, the debounced bit flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- `traffic` is the debounced traffic register, driven directly.
- Emergency arbiter FSM, states IDLE / GRANT / HOLD:
  - IDLE: `emergency`=0. If any debounced emergency bit is high, grant the highest-priority bit (east>west>north>south), register it one-hot and go to GRANT.
  - GRANT: hold the grant while the granted debounced bit stays high. Higher-priority requests do not preempt. When the granted bit drops, load the hold counter with EMG_HOLD-1 and go to HOLD; the grant stays asserted.
  - HOLD: the grant stays asserted and the counter decrements. If the granted bit reasserts, return to GRANT. At count 0, go to IDLE and clear `emergency` on that edge.
  - IDLE re-arbitrates on the next cycle: a pending request gets a grant no sooner than one cycle after clearing, so the output shows at least one zero cycle between grants.
- Pedestrian latch, per bit:
  - Set on a rising edge of the debounced button.
  - Cleared when the matching `ped_served` bit is high.
  - Set and clear in the same cycle: set wins.
  - Holding the button does not re-set the latch after service; only a new edge does.
- Suppression: while `emg_active`=1, `pedastrain_req` is driven 0. Latches keep their contents and reappear the cycle after `emg_active` falls. `ped_served` still clears latches during suppression.

## Timing
- Reset (`reset`=0, asynchronous):
  - Synchronisers, debounced bits, counters and latches all go to 0; FSM goes to IDLE.
  - Outputs: `traffic`=0, `emergency`=0, `pedastrain_req`=0, `emg_active`=0.
- Release: the first active edge is the first rising `clk` with `reset`=1.
- Reset asserted mid-grant or mid-hold: outputs go to 0 immediately, with no clock needed.
- Latency, L = 2 + DEBOUNCE_CYCLES edges from the edge that first samples a stable raw change to the debounced bit updating:
  - `traffic`: L edges (6 at defaults).
  - `emergency`, `emg_active`, `pedastrain_req`: L+1 edges (7 at defaults).
- Glitch rejection: a raw pulse or dropout of ≤ DEBOUNCE_CYCLES-1 cycles (after synchronisation) never changes a debounced bit.
- Emergency release: `emergency` stays asserted exactly EMG_HOLD cycles after the cycle in which the FSM sees the granted debounced bit low.
- Pedestrian clear: `ped_served` high at edge n gives a latch of 0 after edge n.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Debounce: `raw_traffic`=0100 held 10 cycles → `traffic`=0100 exactly 6 edges after first sample. A 3-cycle pulse of `raw_traffic`=0001 → `traffic` stays 0000.
- Priority and no preemption:
  - `raw_emergency`=1010 simultaneously → `emergency`=1000, `emg_active`=1 at edge 7.
  - Drop bit3 only → after debounce, grant held 16 cycles, then 0000 for one cycle, then 0010.
- Hold re-extension: emergency 0001 granted, dropped for 5 cycles, reasserted → `emergency` stays 0001 throughout with no zero cycle.
- Pedestrian latch:
  - `raw_ped`=0100 for 6 cycles then released → `pedastrain_req`=0100 persists.
  - `ped_served`=0100 for 1 cycle → 0000 next edge.
  - Button held through service → no re-request.
- Suppression: latch 1000 set, then emergency 0010 granted → `pedastrain_req`=0000 during grant and 1000 the cycle after `emg_active` falls.
- Reset mid-hold: assert `reset`=0 during HOLD → all outputs 0 before the next clock edge. After release with inputs idle, all outputs stay 0.
